wb_bram_responder: RTL and testbench

//  Wishbone classic-cycle slave serving the DMA master's memory traffic.

---
 rtl/wb_pkg.sv | 15 +
 rtl/wb_bram_responder_if.sv | 23 ++
 rtl/bram_1rw_be.sv | 30 +++
 rtl/wb_bram_responder.sv | 127 ++++++++++++
 tb/tb_wb_bram_responder.sv | 288 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/wb_pkg.sv
// Shared Wishbone/BRAM definitions: responder FSM states and system memory-map anchors.
package wb_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      ACK  = 2'd2
   } state_t;

   // Data BRAM window, FIR tap region inside it, and the DMA start register.
   localparam logic [31:0] BRAM_BASE     = 32'h3800_0000;
   localparam logic [31:0] TAP_BASE      = 32'h3800_0100;
   localparam logic [31:0] DMA_START_REG = 32'h3800_02b0;

endpackage

// File: rtl/wb_bram_responder_if.sv
// Wishbone classic-cycle bus bundle between the DMA master and the BRAM responder.
interface wb_bram_responder_if;

   logic        wbs_cyc_i;
   logic        wbs_stb_i;
   logic        wbs_we_i;
   logic [3:0]  wbs_sel_i;
   logic [31:0] wbs_adr_i;
   logic [31:0] wbs_dat_i;
   logic [31:0] wbs_dat_o;
   logic        wbs_ack_o;

   modport master (
      output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
      input  wbs_dat_o, wbs_ack_o
   );

   modport slave (
      input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
      output wbs_dat_o, wbs_ack_o
   );

endinterface

// File: rtl/bram_1rw_be.sv
// Single-port word RAM with per-byte write enables and a registered (1-cycle) read.
module bram_1rw_be #(
   parameter int unsigned ADDR_W = 10
) (
   input  logic              clk,
   input  logic [ADDR_W-1:0] addr,
   input  logic [3:0]        we,
   input  logic [31:0]       wdata,
   output logic [31:0]       rdata
);

   localparam int unsigned DEPTH = 2 ** ADDR_W;

   logic [31:0] mem [DEPTH];
   logic [31:0] rdata_q;

   // Byte-lane write and read-first registered read of the addressed word.
   // NOTE: storage has no reset so it maps onto block RAM; contents survive rst_n.
   always_ff @(posedge clk) begin
      for (int b = 0; b < 4; b++) begin
         if (we[b]) begin
            mem[addr][8*b +: 8] <= wdata[8*b +: 8];
         end
      end
      rdata_q <= mem[addr];
   end

   assign rdata = rdata_q;

endmodule

// File: rtl/wb_bram_responder.sv
// Wishbone slave for the data BRAM: window decode, fixed wait states, one-cycle ack.
module wb_bram_responder
   import wb_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR = BRAM_BASE,
   parameter int unsigned ADDR_W    = 10,
   parameter int unsigned DELAY     = 10
) (
   input  logic              wb_clk_i,
   input  logic              wb_rst_n_i,
   wb_bram_responder_if.slave wbs,
   output logic              busy_o
);

   localparam int unsigned     CNT_W    = (DELAY > 0) ? $clog2(DELAY + 1) : 1;
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DELAY);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam int unsigned     TAG_LSB  = ADDR_W + 2;

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [ADDR_W-1:0] idx_q, idx_d;
   logic              we_q, we_d;
   logic [3:0]        sel_q, sel_d;
   logic [31:0]       wdat_q, wdat_d;

   logic [ADDR_W-1:0] req_idx;
   logic              hit;
   logic              req_live;
   logic [ADDR_W-1:0] ram_addr;
   logic [3:0]        ram_we;
   logic [31:0]       ram_rdata;
   logic              unused_adr_lsbs;

   assign unused_adr_lsbs = ^wbs.wbs_adr_i[1:0];

   assign req_live = wbs.wbs_cyc_i & wbs.wbs_stb_i;
   assign req_idx  = wbs.wbs_adr_i[ADDR_W+1:2];
   assign hit      = req_live & (wbs.wbs_adr_i[31:TAG_LSB] == BASE_ADDR[31:TAG_LSB]);

   // Next-state, wait counter and request capture.
   always_comb begin
      // NOTE: every output gets a default first so no path leaves a latch behind.
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      we_d    = we_q;
      sel_d   = sel_q;
      wdat_d  = wdat_q;
      unique case (state_q)
         IDLE: begin
            if (hit) begin
               idx_d   = req_idx;
               we_d    = wbs.wbs_we_i;
               sel_d   = wbs.wbs_sel_i;
               wdat_d  = wbs.wbs_dat_i;
               cnt_d   = CNT_LOAD;
               state_d = (DELAY > 0) ? WAIT : ACK;
            end
         end
         WAIT: begin
            // A master that drops cyc/stb abandons the transfer: no ack, no write.
            if (!req_live) begin
               cnt_d   = '0;
               state_d = IDLE;
            end else if (cnt_q == CNT_ONE) begin
               cnt_d   = '0;
               state_d = ACK;
            end else begin
               cnt_d = cnt_q - CNT_ONE;
            end
         end
         ACK: begin
            // Always pass through IDLE so ack can never be high two cycles running.
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and captured-request registers, cleared asynchronously.
   always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values together.
      if (!wb_rst_n_i) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         idx_q   <= '0;
         we_q    <= 1'b0;
         sel_q   <= '0;
         wdat_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         we_q    <= we_d;
         sel_q   <= sel_d;
         wdat_q  <= wdat_d;
      end
   end

   // RAM port: live address while idle (covers the zero-delay accept edge), captured
   // address otherwise, so the final WAIT edge loads the read word for ACK.
   always_comb begin
      ram_addr = (state_q == IDLE) ? req_idx : idx_q;
      ram_we   = ((state_q == ACK) && we_q) ? sel_q : 4'b0000;
   end

   bram_1rw_be #(
      .ADDR_W (ADDR_W)
   ) u_bram (
      .clk   (wb_clk_i),
      .addr  (ram_addr),
      .we    (ram_we),
      .wdata (wdat_q),
      .rdata (ram_rdata)
   );

   // Bus outputs decoded from state so an async reset drops them immediately.
   always_comb begin
      wbs.wbs_ack_o = (state_q == ACK);
      wbs.wbs_dat_o = ((state_q == ACK) && !we_q) ? ram_rdata : 32'h0;
      busy_o        = (state_q != IDLE);
   end

endmodule

// File: tb/tb_wb_bram_responder.sv
// Directed bench for wb_bram_responder: vector table plus multi-cycle corner sequences.
module tb_wb_bram_responder;
   import wb_pkg::*;

   localparam int unsigned DELAY = 10;
   localparam int unsigned NVEC  = 16;

   typedef struct {
      logic        we;
      logic [3:0]  sel;
      logic [31:0] adr;
      logic [31:0] wdat;
      logic [31:0] rexp;
   } vec_t;

   logic clk;
   logic rst_n;
   logic busy;
   int   checks = 0;
   int   errors = 0;

   wb_bram_responder_if bus ();

   wb_bram_responder #(
      .BASE_ADDR (BRAM_BASE),
      .ADDR_W    (10),
      .DELAY     (DELAY)
   ) dut (
      .wb_clk_i   (clk),
      .wb_rst_n_i (rst_n),
      .wbs        (bus),
      .busy_o     (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, time %0t limit 1000000", $time);
      $fatal(1);
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_bus();
      bus.wbs_cyc_i = 1'b0;
      bus.wbs_stb_i = 1'b0;
      bus.wbs_we_i  = 1'b0;
      bus.wbs_sel_i = 4'h0;
      bus.wbs_adr_i = 32'h0;
      bus.wbs_dat_i = 32'h0;
   endtask

   task automatic drive(input logic we, input logic [3:0] sel, input logic [31:0] adr,
                        input logic [31:0] dat);
      bus.wbs_cyc_i = 1'b1;
      bus.wbs_stb_i = 1'b1;
      bus.wbs_we_i  = we;
      bus.wbs_sel_i = sel;
      bus.wbs_adr_i = adr;
      bus.wbs_dat_i = dat;
   endtask

   // Full transfer; lat counts cycles from the accepting edge (cycle 1 follows it).
   task automatic wb_xfer(input logic we, input logic [3:0] sel, input logic [31:0] adr,
                          input logic [31:0] dat, output int lat, output logic [31:0] rdat,
                          output logic busy1, output logic post_ack, output logic [31:0] post_dat);
      int n;
      lat  = -1;
      rdat = 32'h0;
      drive(we, sel, adr, dat);
      tick();
      n     = 1;
      busy1 = busy;
      while (bus.wbs_ack_o !== 1'b1 && n < 40) begin
         tick();
         n++;
      end
      if (bus.wbs_ack_o === 1'b1) begin
         lat  = n;
         rdat = bus.wbs_dat_o;
      end
      idle_bus();
      tick();
      post_ack = bus.wbs_ack_o;
      post_dat = bus.wbs_dat_o;
   endtask

   task automatic do_read(input string name, input logic [31:0] adr, input logic [31:0] exp);
      int          lat;
      logic [31:0] rdat, pdat;
      logic        b1, pack;
      wb_xfer(1'b0, 4'hF, adr, 32'h0, lat, rdat, b1, pack, pdat);
      check({name, " latency"}, 32'(lat), 32'(DELAY + 1));
      check({name, " data"}, rdat, exp);
   endtask

   task automatic do_write(input string name, input logic [3:0] sel, input logic [31:0] adr,
                           input logic [31:0] dat);
      int          lat;
      logic [31:0] rdat, pdat;
      logic        b1, pack;
      wb_xfer(1'b1, sel, adr, dat, lat, rdat, b1, pack, pdat);
      check({name, " latency"}, 32'(lat), 32'(DELAY + 1));
   endtask

   task automatic hold_miss(input string name, input logic cyc, input logic stb,
                            input logic [31:0] adr);
      int acks  = 0;
      int busys = 0;
      bus.wbs_cyc_i = cyc;
      bus.wbs_stb_i = stb;
      bus.wbs_we_i  = 1'b0;
      bus.wbs_sel_i = 4'hF;
      bus.wbs_adr_i = adr;
      repeat (20) begin
         tick();
         if (bus.wbs_ack_o !== 1'b0) acks++;
         if (busy !== 1'b0) busys++;
      end
      idle_bus();
      check({name, " ack count"}, 32'(acks), 32'd0);
      check({name, " busy count"}, 32'(busys), 32'd0);
   endtask

   task automatic count_idle_acks(input string name, input int cycles);
      int acks = 0;
      repeat (cycles) begin
         tick();
         if (bus.wbs_ack_o !== 1'b0) acks++;
      end
      check({name, " stray acks"}, 32'(acks), 32'd0);
   endtask

   vec_t vecs [NVEC];

   initial begin
      int          lat;
      logic [31:0] rdat, pdat;
      logic        b1, pack;
      logic [31:0] taps [11];
      int          n, nacks, pos1, pos2;

      vecs[0]  = '{we:1'b1, sel:4'hF, adr:32'h3800_0100, wdat:32'hDEAD_BEEF, rexp:32'h0};
      vecs[1]  = '{we:1'b0, sel:4'hF, adr:32'h3800_0100, wdat:32'h0,         rexp:32'hDEAD_BEEF};
      vecs[2]  = '{we:1'b1, sel:4'hF, adr:32'h3800_0104, wdat:32'h1122_3344, rexp:32'h0};
      vecs[3]  = '{we:1'b1, sel:4'h2, adr:32'h3800_0104, wdat:32'h0000_AA00, rexp:32'h0};
      vecs[4]  = '{we:1'b0, sel:4'hF, adr:32'h3800_0104, wdat:32'h0,         rexp:32'h1122_AA44};
      vecs[5]  = '{we:1'b1, sel:4'h0, adr:32'h3800_0104, wdat:32'h5566_7788, rexp:32'h0};
      vecs[6]  = '{we:1'b0, sel:4'hF, adr:32'h3800_0107, wdat:32'h0,         rexp:32'h1122_AA44};
      vecs[7]  = '{we:1'b1, sel:4'hF, adr:DMA_START_REG, wdat:32'h0,         rexp:32'h0};
      vecs[8]  = '{we:1'b1, sel:4'h9, adr:DMA_START_REG, wdat:32'hA5A5_A5A5, rexp:32'h0};
      vecs[9]  = '{we:1'b0, sel:4'hF, adr:DMA_START_REG, wdat:32'h0,         rexp:32'hA500_00A5};
      vecs[10] = '{we:1'b1, sel:4'hF, adr:32'h3800_0FFC, wdat:32'hCAFE_F00D, rexp:32'h0};
      vecs[11] = '{we:1'b1, sel:4'hF, adr:32'h3800_0000, wdat:32'h0F0F_0F0F, rexp:32'h0};
      vecs[12] = '{we:1'b0, sel:4'hF, adr:32'h3800_0FFC, wdat:32'h0,         rexp:32'hCAFE_F00D};
      vecs[13] = '{we:1'b0, sel:4'hF, adr:32'h3800_0000, wdat:32'h0,         rexp:32'h0F0F_0F0F};
      vecs[14] = '{we:1'b1, sel:4'h4, adr:32'h3800_0000, wdat:32'h0099_0000, rexp:32'h0};
      vecs[15] = '{we:1'b0, sel:4'hF, adr:32'h3800_0000, wdat:32'h0,         rexp:32'h0F99_0F0F};

      // Reset and idle outputs.
      idle_bus();
      rst_n = 1'b0;
      repeat (3) tick();
      check("reset ack", {31'h0, bus.wbs_ack_o}, 32'h0);
      check("reset busy", {31'h0, busy}, 32'h0);
      check("reset dat_o", bus.wbs_dat_o, 32'h0);
      rst_n = 1'b1;
      repeat (3) tick();
      check("idle ack", {31'h0, bus.wbs_ack_o}, 32'h0);
      check("idle busy", {31'h0, busy}, 32'h0);
      check("idle dat_o", bus.wbs_dat_o, 32'h0);

      // Vector table: latency, single-cycle ack, busy in WAIT, read data.
      for (int i = 0; i < NVEC; i++) begin
         wb_xfer(vecs[i].we, vecs[i].sel, vecs[i].adr, vecs[i].wdat, lat, rdat, b1, pack, pdat);
         check($sformatf("vec%0d latency", i), 32'(lat), 32'(DELAY + 1));
         check($sformatf("vec%0d busy in wait", i), {31'h0, b1}, 32'h1);
         check($sformatf("vec%0d ack after", i), {31'h0, pack}, 32'h0);
         if (!vecs[i].we) begin
            check($sformatf("vec%0d rdata", i), rdat, vecs[i].rexp);
            check($sformatf("vec%0d dat_o after", i), pdat, 32'h0);
         end
      end

      // Misses: outside window, just past window, strobe low inside window.
      hold_miss("miss 0x30000000", 1'b1, 1'b1, 32'h3000_0000);
      hold_miss("miss 0x38001000", 1'b1, 1'b1, 32'h3800_1000);
      hold_miss("stb low", 1'b1, 1'b0, 32'h3800_0100);
      do_read("read after misses", 32'h3800_0100, 32'hDEAD_BEEF);

      // Abort: drop stb three cycles into WAIT.
      do_write("abort preload", 4'hF, 32'h3800_0108, 32'h1234_5678);
      drive(1'b1, 4'hF, 32'h3800_0108, 32'hFFFF_FFFF);
      tick();
      tick();
      tick();
      check("abort busy before drop", {31'h0, busy}, 32'h1);
      bus.wbs_stb_i = 1'b0;
      tick();
      check("abort busy after drop", {31'h0, busy}, 32'h0);
      check("abort ack after drop", {31'h0, bus.wbs_ack_o}, 32'h0);
      idle_bus();
      count_idle_acks("abort", 15);
      do_read("abort readback", 32'h3800_0108, 32'h1234_5678);

      // DMA-style tap sweep.
      for (int i = 0; i < 11; i++) begin
         taps[i] = 32'hA000_0000 + 32'(i) * 32'h0001_0203;
         do_write($sformatf("tap%0d write", i), 4'hF, TAP_BASE + 32'(4 * i), taps[i]);
      end
      for (int i = 0; i < 11; i++) begin
         do_read($sformatf("tap%0d read", i), TAP_BASE + 32'(4 * i), taps[i]);
      end

      // Reset asserted mid-WAIT on a write.
      drive(1'b1, 4'hF, TAP_BASE, 32'hBAD0_BAD0);
      tick();
      repeat (4) tick();
      check("rst-wait busy before", {31'h0, busy}, 32'h1);
      rst_n = 1'b0;
      #1;
      check("rst-wait ack", {31'h0, bus.wbs_ack_o}, 32'h0);
      check("rst-wait busy", {31'h0, busy}, 32'h0);
      idle_bus();
      tick();
      tick();
      rst_n = 1'b1;
      count_idle_acks("rst-wait", 15);
      do_read("rst-wait readback", TAP_BASE, taps[0]);

      // Reset asserted during ACK of a write: ack drops at once, no commit.
      drive(1'b1, 4'hF, TAP_BASE + 32'd4, 32'h0BAD_F00D);
      tick();
      n = 1;
      while (bus.wbs_ack_o !== 1'b1 && n < 40) begin
         tick();
         n++;
      end
      check("rst-ack ack reached", 32'(n), 32'(DELAY + 1));
      rst_n = 1'b0;
      #1;
      check("rst-ack ack dropped", {31'h0, bus.wbs_ack_o}, 32'h0);
      check("rst-ack busy dropped", {31'h0, busy}, 32'h0);
      idle_bus();
      tick();
      tick();
      rst_n = 1'b1;
      tick();
      do_read("rst-ack readback", TAP_BASE + 32'd4, taps[1]);

      // Strobe held through ACK: re-accepted in IDLE, acks never adjacent.
      drive(1'b0, 4'hF, TAP_BASE + 32'd8, 32'h0);
      nacks = 0;
      pos1  = 0;
      pos2  = 0;
      tick();
      for (int c = 1; c <= 25; c++) begin
         if (bus.wbs_ack_o === 1'b1) begin
            nacks++;
            if (nacks == 1) pos1 = c;
            if (nacks == 2) pos2 = c;
         end
         if (c < 25) tick();
      end
      idle_bus();
      tick();
      check("held stb ack count", 32'(nacks), 32'd2);
      check("held stb first ack", 32'(pos1), 32'(DELAY + 1));
      check("held stb second ack", 32'(pos2), 32'(2 * (DELAY + 1) + 1));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
